// File: rtl/maze_link_tx.sv
// maze_link_tx: transmit end of the 9-wire maze-cell link; every accepted word becomes a
// SYNC/DUMMY/D0/D1/D2 strobe frame. Define MAZE_TX_FIFO_EN for a FIFO_DEPTH input queue.
module maze_link_tx #(
    parameter int unsigned HALF_PERIOD = 25,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic [4:0] IN_ADDR,
    input  logic [8:0] IN_DATA,
    output logic [2:0] LINK_DATA,
    output logic       LINK_CLK,
    output logic [4:0] LINK_ADDR,
    output logic       BUSY,
    output logic       ERR_ADDR
);
    localparam int unsigned   CW        = $clog2(HALF_PERIOD) + 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [4:0]    SYNC_ADDR = 5'd31;

    if (HALF_PERIOD < 2 || HALF_PERIOD > 255 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("maze_link_tx: HALF_PERIOD must be 2..255, FIFO_DEPTH a power of two >= 2");
    end

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t        state_q, state_d;
    logic [2:0]    k_q, k_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    cur_addr_q, cur_addr_d;
    logic [8:0]    cur_word_q, cur_word_d;
    logic          clk_q, clk_d;
    logic [4:0]    laddr_q, laddr_d;
    logic [2:0]    ldata_q, ldata_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          ready_q, ready_d;

    logic          accept, push, pop, phase_end, frame_end;
    logic          q_empty;
    logic [4:0]    q_addr;
    logic [8:0]    q_word;

    assign accept    = IN_VALID && ready_q;
    assign push      = accept && (IN_ADDR != SYNC_ADDR);
    assign phase_end = (cnt_q == CNT_LAST);
    assign frame_end = (state_q == HIGH) && (k_q == 3'd4) && phase_end;

`ifdef MAZE_TX_FIFO_EN
    localparam int unsigned   PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT1    = (PW + 1)'(1);
    localparam logic [PW:0]   FULL    = (PW + 1)'(FIFO_DEPTH);

    logic [4:0]    mem_addr_q [FIFO_DEPTH];
    logic [8:0]    mem_word_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;

    assign q_empty = (count_q == '0);
    assign q_addr  = mem_addr_q[rd_ptr_q];
    assign q_word  = mem_word_q[rd_ptr_q];
    // The next word is taken on the same edge HIGH(4) ends, so frames abut.
    assign pop     = !q_empty && ((state_q == IDLE) || frame_end);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT1;
        end else if (pop && !push) begin
            count_d = count_q - CNT1;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= IN_ADDR;
            mem_word_q[wr_ptr_q] <= IN_DATA;
        end
    end
`else
    logic       hold_q, hold_d;
    logic [4:0] hold_addr_q;
    logic [8:0] hold_word_q;

    assign q_empty = !hold_q;
    assign q_addr  = hold_addr_q;
    assign q_word  = hold_word_q;
    assign pop     = hold_q && (state_q == IDLE);

    always_comb begin
        hold_d = hold_q;
        if (push) begin
            hold_d = 1'b1;
        end else if (pop) begin
            hold_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) hold_q <= 1'b0;
        else       hold_q <= hold_d;
    end

    always_ff @(posedge CLOCK) begin
        if (push) begin
            hold_addr_q <= IN_ADDR;
            hold_word_q <= IN_DATA;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        cur_addr_d = cur_addr_q;
        cur_word_d = cur_word_q;
        clk_d      = clk_q;
        laddr_d    = laddr_q;
        ldata_d    = ldata_q;
        busy_d     = busy_q;
        err_d      = accept && (IN_ADDR == SYNC_ADDR);
        if (pop) begin
            state_d    = LOW;
            k_d        = '0;
            cnt_d      = '0;
            cur_addr_d = q_addr;
            cur_word_d = q_word;
            clk_d      = 1'b0;
            laddr_d    = SYNC_ADDR;
            ldata_d    = '0;
            busy_d     = 1'b1;
        end else if (state_q != IDLE) begin
            if (!phase_end) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = '0;
                if (state_q == LOW) begin
                    state_d = HIGH;
                    clk_d   = 1'b1;
                end else if (frame_end) begin
                    state_d = IDLE;
                    clk_d   = 1'b0;
                    laddr_d = SYNC_ADDR;
                    ldata_d = '0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = LOW;
                    k_d     = k_q + 3'd1;
                    clk_d   = 1'b0;
                    laddr_d = cur_addr_q;
                    case (k_q)
                        3'd1:    ldata_d = cur_word_q[2:0];
                        3'd2:    ldata_d = cur_word_q[5:3];
                        3'd3:    ldata_d = cur_word_q[8:6];
                        default: ldata_d = '0;
                    endcase
                end
            end
        end
`ifdef MAZE_TX_FIFO_EN
        ready_d = (count_d != FULL);
`else
        // Ready is raised for the last HIGH(4) cycle so a word can be taken on the final fall.
        ready_d = !hold_d && ((state_d == IDLE) ||
                  ((state_d == HIGH) && (k_d == 3'd4) && (cnt_d == CNT_LAST)));
`endif
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            k_q        <= '0;
            cnt_q      <= '0;
            cur_addr_q <= '0;
            cur_word_q <= '0;
            clk_q      <= 1'b0;
            laddr_q    <= SYNC_ADDR;
            ldata_q    <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            cur_addr_q <= cur_addr_d;
            cur_word_q <= cur_word_d;
            clk_q      <= clk_d;
            laddr_q    <= laddr_d;
            ldata_q    <= ldata_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
        end
    end

    assign IN_READY  = ready_q;
    assign LINK_CLK  = clk_q;
    assign LINK_ADDR = laddr_q;
    assign LINK_DATA = ldata_q;
    assign BUSY      = busy_q;
    assign ERR_ADDR  = err_q;
endmodule

// File: tb/tb_maze_link_tx.sv
// tb_maze_link_tx: drives maze_link_tx with directed and random words; checks strobe timing,
// a display-receiver model against a word scoreboard, reserved-address and reset handling.
`timescale 1ns/1ps
module tb_maze_link_tx;
    localparam int unsigned HP    = 4;
    localparam int unsigned DEPTH = 4;
`ifdef MAZE_TX_FIFO_EN
    localparam int FRAME_PERIOD = 10 * HP;
    localparam int STALL_AFTER  = DEPTH + 1;
`else
    localparam int FRAME_PERIOD = 10 * HP + 1;
    localparam int STALL_AFTER  = 1;
`endif

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       IN_VALID;
    logic       IN_READY;
    logic [4:0] IN_ADDR;
    logic [8:0] IN_DATA;
    logic [2:0] LINK_DATA;
    logic       LINK_CLK;
    logic [4:0] LINK_ADDR;
    logic       BUSY;
    logic       ERR_ADDR;

    maze_link_tx #(.HALF_PERIOD(HP), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_ADDR(IN_ADDR), .IN_DATA(IN_DATA), .LINK_DATA(LINK_DATA), .LINK_CLK(LINK_CLK),
        .LINK_ADDR(LINK_ADDR), .BUSY(BUSY), .ERR_ADDR(ERR_ADDR)
    );

    always #5 CLOCK = ~CLOCK;

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard of {addr, word} for every non-reserved accepted word, in order.
    logic [13:0] sb [$];
    int          rise_cyc [$];
    logic [7:0]  rise_val [$];
    logic [8:0]  ram [32];
    bit          ram_wr [32];
    int          rx_pos = 4;
    logic [8:0]  rx_w = '0;
    int          rx_writes = 0;
    int          err_pulses = 0;
    int          unstable = 0;
    bit          prev_clk = 1'b0;
    logic [7:0]  prev_bus = '0;

    // Display receiver: SYNC restarts the position; the word is written on its third data strobe.
    task automatic rx_strobe(input logic [4:0] a, input logic [2:0] d);
        logic [13:0] e;
        if (a == 5'd31) begin
            rx_pos = 0;
        end else begin
            case (rx_pos)
                1: rx_w[2:0] = d;
                2: rx_w[5:3] = d;
                3: begin
                    rx_w[8:6] = d;
                    ram[a]    = rx_w;
                    ram_wr[a] = 1'b1;
                    rx_writes++;
                    chk("rx_expected_word", sb.size() > 0, 1'b1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("rx_addr", a, e[13:9]);
                        chk("rx_word", rx_w, e[8:0]);
                    end
                end
                default: ;
            endcase
            rx_pos++;
        end
    endtask

    always @(negedge CLOCK) begin
        if (!RESET) begin
            if (LINK_CLK && ({LINK_ADDR, LINK_DATA} !== prev_bus)) unstable++;
            if (!prev_clk && LINK_CLK) begin
                rise_cyc.push_back(cyc);
                rise_val.push_back({LINK_ADDR, LINK_DATA});
                rx_strobe(LINK_ADDR, LINK_DATA);
            end
            if (ERR_ADDR) err_pulses++;
        end
        prev_clk = LINK_CLK;
        prev_bus = {LINK_ADDR, LINK_DATA};
    end

    function automatic logic [7:0] strobe_exp(input int k, input logic [4:0] a, input logic [8:0] w);
        logic [8:0] ww;
        ww = w;
        if (k == 0) return {5'd31, 3'd0};
        if (k == 1) return {a, 3'd0};
        return {a, ww[3*(k-2) +: 3]};
    endfunction

    task automatic step();
        @(negedge CLOCK);
        #1;
    endtask

    task automatic idle(input int n);
        IN_VALID = 1'b0;
        repeat (n) step();
    endtask

    // Offers one word and waits (bounded) for the handshake; t_acc is the accepting edge.
    task automatic send(input logic [4:0] a, input logic [8:0] w, output int t_acc);
        int budget;
        budget = 0;
        IN_VALID = 1'b1;
        IN_ADDR  = a;
        IN_DATA  = w;
        while (!IN_READY && budget < 40 * HP) begin
            step();
            budget++;
        end
        chk("in_ready_wait", IN_READY, 1'b1);
        if (!IN_READY) begin
            IN_VALID = 1'b0;
            t_acc = -1;
            return;
        end
        @(posedge CLOCK);
        #1;
        t_acc = cyc;
        if (a != 5'd31) sb.push_back({a, w});
        IN_VALID = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n, r0, e0, w0, imm, reserved, sent;
        bit stalled;
        logic [8:0] w, words [3];
        logic [4:0] addrs [3];
        int syncs [$];

        RESET = 1'b1; IN_VALID = 1'b0; IN_ADDR = '0; IN_DATA = '0;
        repeat (3) step();
        chk("rst_link_clk", LINK_CLK, 1'b0);
        chk("rst_link_addr", LINK_ADDR, 5'd31);
        chk("rst_link_data", LINK_DATA, 3'd0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_err", ERR_ADDR, 1'b0);
        chk("rst_ready", IN_READY, 1'b1);
        RESET = 1'b0;
        idle(2);

        // Single frame: strobe timing, contents and BUSY window.
        rise_cyc.delete(); rise_val.delete();
        w = 9'b101_0110_11;
        send(5'd5, w, t);
        n = 0; r0 = -1;
        repeat (12 * HP) begin
            step();
            if (BUSY) begin
                n++;
                if (r0 < 0) r0 = cyc;
            end
        end
        chk("t1_busy_start", r0, t + 1);
        chk("t1_busy_len", n, 10 * HP);
        chk("t1_rise_count", rise_cyc.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < rise_cyc.size()) begin
                chk("t1_rise_cycle", rise_cyc[k], t + 1 + HP + 2 * HP * k);
                chk("t1_rise_value", rise_val[k], strobe_exp(k, 5'd5, w));
            end
        end
        chk("t1_idle_clk", LINK_CLK, 1'b0);
        chk("t1_idle_addr", LINK_ADDR, 5'd31);
        chk("t1_idle_data", LINK_DATA, 3'd0);
        chk("t1_idle_ready", IN_READY, 1'b1);

        // Receiver RAM holds exactly the words sent.
        for (int i = 0; i < 32; i++) ram_wr[i] = 1'b0;
        addrs[0] = 5'd0; addrs[1] = 5'd7; addrs[2] = 5'd19;
        for (int i = 0; i < 3; i++) begin
            words[i] = 9'($urandom);
            send(addrs[i], words[i], t);
        end
        idle(12 * HP);
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(ram_wr[i]);
        chk("t2_ram_entries", n, 3);
        for (int i = 0; i < 3; i++) chk("t2_ram_word", ram[addrs[i]], words[i]);
        chk("t2_sb_empty", sb.size(), 0);

        // Reserved address: handshake completes, ERR_ADDR pulses, nothing transmitted.
        r0 = rise_cyc.size(); e0 = err_pulses;
        send(5'd31, 9'($urandom), t);
        chk("t3_err_high", ERR_ADDR, 1'b1);
        chk("t3_ready_high", IN_READY, 1'b1);
        step(); step();
        chk("t3_err_low", ERR_ADDR, 1'b0);
        idle(10 * HP);
        chk("t3_no_rise", rise_cyc.size(), r0);
        chk("t3_err_pulses", err_pulses - e0, 1);
        chk("t3_busy", BUSY, 1'b0);
        chk("t3_ready", IN_READY, 1'b1);

        // Reset during HIGH(2): link drops at once, no more strobes, next word decodes.
        r0 = rise_cyc.size();
        send(5'd9, 9'($urandom), t);
        n = 0;
        while (rise_cyc.size() < r0 + 3 && n < 20 * HP) begin
            step();
            n++;
        end
        chk("t4_reach_high2", rise_cyc.size() >= r0 + 3, 1'b1);
        RESET = 1'b1;
        #1;
        chk("t4_rst_clk", LINK_CLK, 1'b0);
        chk("t4_rst_addr", LINK_ADDR, 5'd31);
        chk("t4_rst_busy", BUSY, 1'b0);
        sb.delete();
        repeat (2) step();
        RESET = 1'b0;
        idle(15 * HP);
        chk("t4_no_rise_after_reset", rise_cyc.size(), r0 + 3);
        ram_wr[12] = 1'b0;
        w = 9'($urandom);
        send(5'd12, w, t);
        idle(12 * HP);
        chk("t4_rx_written", ram_wr[12], 1'b1);
        chk("t4_rx_word", ram[12], w);

        // Back-to-back words: acceptance before stall and SYNC-to-SYNC period.
        r0 = rise_cyc.size();
        imm = 0; stalled = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!stalled && IN_READY) imm++;
            else stalled = 1'b1;
            send(5'($urandom_range(0, 30)), 9'($urandom), t);
        end
        idle(6 * FRAME_PERIOD + 4 * HP);
        chk("t5_accept_before_stall", imm, STALL_AFTER);
        syncs.delete();
        for (int i = r0; i < rise_val.size(); i++) begin
            if (rise_val[i][7:3] == 5'd31) syncs.push_back(rise_cyc[i]);
        end
        chk("t5_frames", syncs.size(), 6);
        for (int i = 1; i < syncs.size(); i++) chk("t5_period", syncs[i] - syncs[i-1], FRAME_PERIOD);
        chk("t5_sb_empty", sb.size(), 0);

        // Random traffic with gaps and occasional reserved addresses.
        e0 = err_pulses; w0 = rx_writes; reserved = 0; sent = 0;
        for (int i = 0; i < 150; i++) begin
            send(5'($urandom_range(0, 31)), 9'($urandom), t);
            if (IN_ADDR == 5'd31) reserved++;
            else sent++;
            idle($urandom_range(0, 3));
        end
        idle(6 * FRAME_PERIOD);
        chk("t6_sb_empty", sb.size(), 0);
        chk("t6_rx_writes", rx_writes - w0, sent);
        chk("t6_err_pulses", err_pulses - e0, reserved);
        chk("link_stable_while_high", unstable, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
